// File: rtl/uc_multiciclo.sv
// Multicycle control unit: fetches RISC-V words over req/ack, decodes LD/SD/ADD/SUB/ADDI/SUBI
// and sequences the datapath. Define UC_PERF_CNT_EN to add cycle_cnt/instret_cnt outputs.
module uc_multiciclo #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rw,
  output logic        WE_reg,
  output logic        WE_mem,
  output logic [63:0] OFFSET,
  output logic [1:0]  OP_MEM_I,
  output logic        ADD_SUB,
  output logic        retired,
  output logic        trap
`ifdef UC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [1:0] {K_ALU, K_LD, K_SD} kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [63:0] off;
    logic [1:0]  op;
    logic        sub;
  } ctrl_t;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d, dec;
  logic        dec_legal;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_i, imm_s;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{52{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{52{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};

  // Instruction classification; only consumed in DECODE.
  always_comb begin
    dec_legal = 1'b1;
    dec.kind  = K_ALU;
    dec.ra    = ir_q[19:15];
    dec.rb    = 5'd0;
    dec.rw    = ir_q[11:7];
    dec.off   = 64'd0;
    dec.op    = 2'd0;
    dec.sub   = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        dec.rb  = ir_q[24:20];
        dec.sub = (funct7 == 7'b0100000);
        dec_legal = (funct3 == 3'b000) && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      7'b0010011, 7'b0001011: begin
        dec.off   = imm_i;
        dec.op    = 2'd2;
        dec.sub   = (opcode == 7'b0001011);
        dec_legal = (funct3 == 3'b000);
      end
      7'b0000011: begin
        dec.kind  = K_LD;
        dec.ra    = 5'd0;
        dec.rb    = ir_q[19:15];
        dec.off   = imm_i;
        dec.op    = 2'd1;
        dec_legal = (funct3 == 3'b011);
      end
      7'b0100011: begin
        dec.kind  = K_SD;
        dec.ra    = ir_q[24:20];
        dec.rb    = ir_q[19:15];
        dec.rw    = 5'd0;
        dec.off   = imm_s;
        dec.op    = 2'd1;
        dec_legal = (funct3 == 3'b011);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and has priority.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (ctrl_q.kind == K_ALU) ? S_WB : S_MEM;
      S_MEM:    state_d = (ctrl_q.kind == K_SD) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: strobes are gated by reset so nothing fires while reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    WE_reg   = 1'b0;
    WE_mem   = 1'b0;
    retired  = 1'b0;
    trap     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: imem_req = 1'b1;
        S_MEM: begin
          WE_mem  = (ctrl_q.kind == K_SD);
          retired = (ctrl_q.kind == K_SD);
        end
        S_WB: begin
          WE_reg  = (ctrl_q.rw != 5'd0);
          retired = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ir_d   = ir_q;
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    if (state_q == S_FETCH && imem_ack) ir_d = imem_data;
    if (state_q == S_DECODE && dec_legal) ctrl_d = dec;
    if (retired) pc_d = pc_q + 64'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ir_q   <= '0;
      ctrl_q <= '{kind: K_ALU, default: '0};
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign imem_addr = pc_q;
  assign Ra        = ctrl_q.ra;
  assign Rb        = ctrl_q.rb;
  assign Rw        = ctrl_q.rw;
  assign OFFSET    = ctrl_q.off;
  assign OP_MEM_I  = ctrl_q.op;
  assign ADD_SUB   = ctrl_q.sub;

`ifdef UC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      instret_cnt_q <= instret_cnt_q + {31'd0, retired};
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: randomized fetch stream, reference decode model,
// a second instance near the top of the address space to exercise PC wrap.
module tb_uc_multiciclo;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [63:0] imem_addr, OFFSET;
  logic        imem_req, WE_reg, WE_mem, ADD_SUB, retired, trap;
  logic [4:0]  Ra, Rb, Rw;
  logic [1:0]  OP_MEM_I;

  logic [63:0] w_imem_addr, w_OFFSET;
  logic        w_imem_req, w_WE_reg, w_WE_mem, w_ADD_SUB, w_retired, w_trap;
  logic [4:0]  w_Ra, w_Rb, w_Rw;
  logic [1:0]  w_OP_MEM_I;

  uc_multiciclo dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .Ra(Ra), .Rb(Rb), .Rw(Rw),
    .WE_reg(WE_reg), .WE_mem(WE_mem), .OFFSET(OFFSET), .OP_MEM_I(OP_MEM_I),
    .ADD_SUB(ADD_SUB), .retired(retired), .trap(trap)
  );

  uc_multiciclo #(.RESET_PC(WRAP_PC), .PC_STEP(4)) dut_w (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_req(w_imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .Ra(w_Ra), .Rb(w_Rb), .Rw(w_Rw),
    .WE_reg(w_WE_reg), .WE_mem(w_WE_mem), .OFFSET(w_OFFSET), .OP_MEM_I(w_OP_MEM_I),
    .ADD_SUB(w_ADD_SUB), .retired(w_retired), .trap(w_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          legal;
    int          lat;
    bit          sd;
    logic [4:0]  ra, rb, rw;
    logic [63:0] off;
    logic [1:0]  op;
    logic        sub;
    logic [63:0] pc;
    longint      ack_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  logic [63:0] model_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {52'd0, v} - (v[11] ? 64'd4096 : 64'd0);
  endfunction

  // Reference decode straight from the instruction table.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int opc, f3, f7;
    opc = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    e.legal = 0; e.lat = 3; e.sd = 0; e.ra = 0; e.rb = 0; e.rw = 0;
    e.off = 0; e.op = 0; e.sub = 0; e.pc = 0; e.ack_cyc = 0;
    if (opc == 'h33 && f3 == 0 && (f7 == 0 || f7 == 'h20)) begin
      e.legal = 1; e.ra = w[19:15]; e.rb = w[24:20]; e.rw = w[11:7]; e.sub = (f7 == 'h20);
    end else if ((opc == 'h13 || opc == 'h0B) && f3 == 0) begin
      e.legal = 1; e.ra = w[19:15]; e.rw = w[11:7]; e.off = sext12(w[31:20]);
      e.op = 2; e.sub = (opc == 'h0B);
    end else if (opc == 'h03 && f3 == 3) begin
      e.legal = 1; e.lat = 4; e.rb = w[19:15]; e.rw = w[11:7]; e.off = sext12(w[31:20]); e.op = 1;
    end else if (opc == 'h23 && f3 == 3) begin
      e.legal = 1; e.sd = 1; e.ra = w[24:20]; e.rb = w[19:15];
      e.off = sext12({w[31:25], w[11:7]}); e.op = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    imm = 12'($urandom);
    if ($urandom_range(0, 7) == 0) rd = 5'd0;
    case ($urandom_range(0, 5))
      0:       return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      1:       return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
      2:       return {imm, rs1, 3'b000, rd, 7'b0010011};
      3:       return {imm, rs1, 3'b000, rd, 7'b0001011};
      4:       return {imm, rs1, 3'b011, rd, 7'b0000011};
      default: return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endcase
  endfunction

  // Waits for a request, stalls `delay` cycles, acks one cycle; returns in the DECODE cycle.
  task automatic fetch(input logic [31:0] w, input int delay, input bit push);
    exp_t e;
    int   n = 0;
    while (imem_req !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("fetch_req_rise", {63'd0, imem_req}, 64'd1);
    for (int i = 0; i < delay; i++) begin
      check("req_held", {63'd0, imem_req}, 64'd1);
      @(posedge clk); #1;
    end
    check("imem_addr", imem_addr, model_pc);
    check("imem_addr_wrap", w_imem_addr, model_pc + WRAP_PC);
    e = model(w);
    e.pc = model_pc;
    e.ack_cyc = cyc;
    if (push && e.legal) begin
      sb.push_back(e);
      model_pc = model_pc + 64'd4;
    end
    imem_ack  = 1'b1;
    imem_data = w;
    @(posedge clk); #1;
    imem_ack  = 1'b0;
    imem_data = $urandom;
    check("req_drop", {63'd0, imem_req}, 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain_scoreboard", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every retire is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (retired) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 64'(cyc - e.ack_cyc), 64'(e.lat));
          check("Ra", {59'd0, Ra}, {59'd0, e.ra});
          check("Rb", {59'd0, Rb}, {59'd0, e.rb});
          check("Rw", {59'd0, Rw}, {59'd0, e.rw});
          check("OFFSET", OFFSET, e.off);
          check("OP_MEM_I", {62'd0, OP_MEM_I}, {62'd0, e.op});
          check("ADD_SUB", {63'd0, ADD_SUB}, {63'd0, e.sub});
          check("WE_reg", {63'd0, WE_reg}, {63'd0, !e.sd && e.rw != 5'd0});
          check("WE_mem", {63'd0, WE_mem}, {63'd0, e.sd});
          check("pc_at_retire", imem_addr, e.pc);
          check("pc_at_retire_wrap", w_imem_addr, e.pc + WRAP_PC);
        end
      end else begin
        check("stray_we", {62'd0, WE_reg, WE_mem}, 64'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = '0; model_pc = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_trap", {63'd0, trap}, 64'd0);
    check("rst_we", {62'd0, WE_reg, WE_mem}, 64'd0);
    check("rst_retired", {63'd0, retired}, 64'd0);
    check("rst_fields", {Ra, Rb, Rw, OP_MEM_I, ADD_SUB}, 64'd0);
    check("rst_offset", OFFSET, 64'd0);
    check("rst_pc", imem_addr, 64'd0);
    check("rst_pc_wrap", w_imem_addr, WRAP_PC);
    reset = 1'b0;

    // Directed: ADDI x5,x0,7
    fetch(32'h0070_0293, 0, 1);
    @(posedge clk); #1;
    check("addi_offset", OFFSET, 64'd7);
    check("addi_rw", {59'd0, Rw}, 64'd5);
    check("addi_op", {62'd0, OP_MEM_I}, 64'd2);
    fetch(32'h0020_81B3, 0, 1);   // ADD x3,x1,x2
    fetch(32'h4020_81B3, 1, 1);   // SUB x3,x1,x2
    fetch(32'h0080_B203, 0, 1);   // LD x4,8(x1)
    fetch(32'hFE41_3C23, 2, 1);   // SD x4,-8(x2)
    @(posedge clk); #1;
    check("sd_offset", OFFSET, 64'hFFFF_FFFF_FFFF_FFF8);
    check("sd_ra_rb", {54'd0, Ra, Rb}, {54'd0, 5'd4, 5'd2});
    fetch(32'h0032_830B, 5, 1);   // SUBI x6,x5,3 after a 5-cycle stall
    drain();
    check("pc_after_directed", imem_addr, 64'd24);

    for (int i = 0; i < 150; i++) fetch(gen_instr(), int'($urandom_range(0, 3)), 1);
    drain();

    // Reset during EXEC of ADD x0,x1,x2: no write, PC reloads.
    fetch(32'h0020_8033, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_we_reg", {63'd0, WE_reg}, 64'd0);
    check("abort_retired", {63'd0, retired}, 64'd0);
    reset = 1'b0;
    #1;
    check("abort_fetch_req", {63'd0, imem_req}, 64'd1);
    check("abort_pc", imem_addr, 64'd0);
    model_pc = 64'd0;

    fetch(32'h0070_0293, 0, 1);
    fetch(32'h0080_B203, 1, 1);
    drain();

    // Illegal word: trap is sticky, fetch stops, PC frozen.
    fetch(32'hFFFF_FFFF, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("trap_set", {63'd0, trap}, 64'd1);
      check("trap_req", {63'd0, imem_req}, 64'd0);
      check("trap_pc", imem_addr, model_pc);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("trap_cleared", {63'd0, trap}, 64'd0);
    reset = 1'b0;
    #1;
    check("post_trap_pc", imem_addr, 64'd0);
    check("post_trap_req", {63'd0, imem_req}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
